rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
Shares the single regfile write port (we3/a3/wd3) between the in-order pipeline writeback stage and a multi-cycle execution unit (load miss / divider). Multi-cycle results are queued in a small FIFO and written only in idle port cycles. A per-register scoreboard tracks destinations still owed by the multi-cycle unit and raises a hazard for the decode stage. Sits between the writeback mux and the regfile.

Parameters:
XLEN, 32, data width
AW, 5, register address width (2**AW registers, x0 hardwired zero)
FIFO_DEPTH, 2, multi-cycle result queue entries (power of 2, >=2)
STARVE_MAX, 4, consecutive lost arbitration cycles before stall_req asserts

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
p_we  in  1  pipeline writeback enable; never backpressured
p_rd  in  AW  pipeline destination register
p_wd  in  XLEN  pipeline writeback data
m_valid  in  1  multi-cycle result valid
m_rd  in  AW  multi-cycle destination register
m_wd  in  XLEN  multi-cycle result data
m_ready  out  1  FIFO can accept (= not full)
iss_valid  in  1  multi-cycle op issued this cycle
iss_rd  in  AW  destination of issued op
iss_ready  out  1  issue allowed (= !pend[iss_rd])
chk_rs1  in  AW  decode source 1
chk_rs2  in  AW  decode source 2
chk_rd  in  AW  decode destination (WAW check)
hazard  out  1  any of chk_rs1/rs2/rd nonzero and pending
stall_req  out  1  asks front end to bubble so FIFO can drain
we3  out  1  regfile write enable
a3  out  AW  regfile write address
wd3  out  XLEN  regfile write data
err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): FIFO empty, pend[] all 0, starve_cnt=0, err=0; outputs we3=0, a3=0, wd3=0, m_ready=1, iss_ready=1, hazard=0, stall_req=0. we3 forced 0 while reset low.
- Port arbitration (combinational, same cycle): P wins if p_we && p_rd!=0 -> we3=1, a3=p_rd, wd3=p_wd. Else if FIFO non-empty -> pop head, we3=1, a3/wd3=head. Else we3=0, a3=0, wd3=0.
- p_we with p_rd=0: no write, does not block the FIFO pop that cycle.
- FIFO push on m_valid && m_ready at clock edge; entries with m_rd=0 accepted but not enqueued. Push and pop same cycle when full: m_ready reflects full state before pop (no combinational pop->ready path). Min M latency to regfile: 1 cycle after acceptance.
- Wrap-around: circular pointers with extra MSB for full/empty.
- Scoreboard: pend[iss_rd] set at edge on iss_valid && iss_ready && iss_rd!=0. pend[a3] cleared at edge when the FIFO entry is written. Same-reg set and clear in one cycle impossible (iss_ready=0 while pending). Clear becomes visible next cycle; hazard uses registered pend (no bypass).
- hazard = (chk_rs1!=0 && pend[chk_rs1]) || (chk_rs2!=0 && pend[chk_rs2]) || (chk_rd!=0 && pend[chk_rd]).
- err set (sticky until reset) on: m_valid && m_ready with m_rd!=0 and pend[m_rd]=0; iss_valid while iss_ready=0.
- Starvation: starve_cnt increments each cycle FIFO non-empty and P wins; resets to 0 on any pop or when FIFO empty; saturates at STARVE_MAX. stall_req = (starve_cnt==STARVE_MAX); drops the cycle after the pop. P still has priority while stall_req=1.
- Reset mid-operation: queued results discarded, pending bits lost; environment reissues.

Test Plan:
- Reset then idle -> we3=0, m_ready=1, iss_ready=1, hazard=0, err=0.
- iss_rd=5; two cycles later m_valid rd=5 wd=0xDEADBEEF, p_we=0 -> next cycle we3=1 a3=5 wd3=0xDEADBEEF; hazard for chk_rs1=5 high until the cycle after write.
- Issue rd=3,rd=4; push both results while p_we=1 (rd=7) for 6 cycles -> m_ready=0 after 2 pushes, stall_req=1 after 4 lost cycles, regfile gets x7 writes, then x3 then x4 in order once p_we drops.
- Simultaneous P write (rd=9) and non-empty FIFO -> a3=9 that cycle, FIFO head written next free cycle, no data loss.
- m_valid rd=6 with pend[6]=0 -> err=1 and stays 1; iss_valid rd=2 twice without completion -> iss_ready=0 second time, err=1.
- Assert reset with 2 queued entries -> we3 immediately 0, m_ready=1, pend all 0 after release.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Bundle of the regfile write-port arbiter's bus signals.
//               Groups the pipeline writeback input, the multi-cycle result
//               handshake, the issue check, the decode hazard query and the
//               regfile write port.
//   master : environment side (pipeline, multi-cycle unit, decode, regfile)
//   slave  : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // Pipeline writeback stage
    logic            p_we;
    logic [AW-1:0]   p_rd;
    logic [XLEN-1:0] p_wd;
    // Multi-cycle result handshake
    logic            m_valid;
    logic [AW-1:0]   m_rd;
    logic [XLEN-1:0] m_wd;
    logic            m_ready;
    // Multi-cycle issue
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            iss_ready;
    // Decode hazard query
    logic [AW-1:0]   chk_rs1;
    logic [AW-1:0]   chk_rs2;
    logic [AW-1:0]   chk_rd;
    logic            hazard;
    // Front-end stall request and protocol error
    logic            stall_req;
    logic            err;
    // Regfile write port
    logic            we3;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;

    modport master (
        output p_we, p_rd, p_wd,
        output m_valid, m_rd, m_wd,
        input  m_ready,
        output iss_valid, iss_rd,
        input  iss_ready,
        output chk_rs1, chk_rs2, chk_rd,
        input  hazard, stall_req, err,
        input  we3, a3, wd3
    );

    modport slave (
        input  p_we, p_rd, p_wd,
        input  m_valid, m_rd, m_wd,
        output m_ready,
        input  iss_valid, iss_rd,
        output iss_ready,
        input  chk_rs1, chk_rs2, chk_rd,
        output hazard, stall_req, err,
        output we3, a3, wd3
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the single regfile write port between the in-order
//               writeback stage (always wins) and a multi-cycle unit whose
//               results are queued in a small FIFO and drained in idle port
//               cycles. A per-register pending scoreboard raises a decode
//               hazard for destinations still owed by the multi-cycle unit.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low; clears all state
//               bus   - rf_wb_arbiter_if.slave (pipeline/multi-cycle inputs,
//                       issue check, hazard query, stall_req, err, we3/a3/wd3)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    rf_wb_arbiter_if.slave  bus
);
    localparam int NREG = 1 << AW;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]   fifo_rd_q [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_wd_q [FIFO_DEPTH];
    // Pointers carry one extra MSB so full and empty are distinguishable
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            err_q, err_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic            fifo_empty;
    logic            fifo_full;
    logic [AW-1:0]   head_rd;
    logic [XLEN-1:0] head_wd;
    logic            p_win;
    logic            pop;
    logic            push_acc;
    logic            push;
    logic            iss_set;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_rd    = fifo_rd_q[rd_ptr_q[PW-1:0]];
    assign head_wd    = fifo_wd_q[rd_ptr_q[PW-1:0]];

    // A pipeline write to x0 is a no-op and leaves the port free for the FIFO
    assign p_win      = bus.p_we && (bus.p_rd != '0);
    assign pop        = !p_win && !fifo_empty;

    // Ready depends only on registered fullness; a same-cycle pop does not
    // open a slot, keeping the pop->ready path out of the logic cone.
    assign push_acc   = bus.m_valid && !fifo_full;
    assign push       = push_acc && (bus.m_rd != '0);
    assign iss_set    = bus.iss_valid && !pend_q[bus.iss_rd] && (bus.iss_rd != '0);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.m_ready   = !fifo_full;
    assign bus.iss_ready = !pend_q[bus.iss_rd];
    assign bus.hazard    = ((bus.chk_rs1 != '0) && pend_q[bus.chk_rs1]) ||
                           ((bus.chk_rs2 != '0) && pend_q[bus.chk_rs2]) ||
                           ((bus.chk_rd  != '0) && pend_q[bus.chk_rd]);
    assign bus.stall_req = (starve_q == STARVE_LIM);
    assign bus.err       = err_q;

    // The write port is gated by reset so a held pipeline write cannot reach
    // the regfile while the block is being cleared.
    always_comb begin
        bus.we3 = 1'b0;
        bus.a3  = '0;
        bus.wd3 = '0;
        if (reset) begin
            if (p_win) begin
                bus.we3 = 1'b1;
                bus.a3  = bus.p_rd;
                bus.wd3 = bus.p_wd;
            end else if (pop) begin
                bus.we3 = 1'b1;
                bus.a3  = head_rd;
                bus.wd3 = head_wd;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);

        // The cleared and set registers never coincide: an issue to a
        // pending register is refused.
        pend_d = pend_q;
        if (pop) begin
            pend_d[head_rd] = 1'b0;
        end
        if (iss_set) begin
            pend_d[bus.iss_rd] = 1'b1;
        end

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end

        err_d = err_q;
        if (push && !pend_q[bus.m_rd]) begin
            err_d = 1'b1;
        end
        if (bus.iss_valid && pend_q[bus.iss_rd]) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_q   <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Queue storage needs no reset: the pointers define which slots are live
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q[PW-1:0]] <= bus.m_rd;
            fifo_wd_q[wr_ptr_q[PW-1:0]] <= bus.m_wd;
        end
    end

endmodule
`default_nettype wire
